// File: rtl/cpu_debug_controller_if.sv
// Handshake and control bundle between the debug host side and the
// cpu_debug_controller sequencer.
interface cpu_debug_controller_if #(
   parameter int unsigned COUNT_W = 15
);
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic               load_start;
   logic [COUNT_W-1:0] load_word_count;
   logic               run_cmd;
   logic               step_cmd;
   logic               halt_cmd;
   logic               fault;
   logic               instruction_write;
   logic [31:0]        instruction_in;
   logic               debug_enable;
   logic               cpu_rst;
   logic               fault_latched;
   logic [COUNT_W-1:0] words_loaded;
   logic [2:0]         state;

   modport master (
      output byte_valid, byte_data, load_start, load_word_count,
             run_cmd, step_cmd, halt_cmd, fault,
      input  byte_ready, instruction_write, instruction_in, debug_enable,
             cpu_rst, fault_latched, words_loaded, state
   );

   modport slave (
      input  byte_valid, byte_data, load_start, load_word_count,
             run_cmd, step_cmd, halt_cmd, fault,
      output byte_ready, instruction_write, instruction_in, debug_enable,
             cpu_rst, fault_latched, words_loaded, state
   );
endinterface

// File: rtl/cpu_debug_controller.sv
// Front-end sequencer for the RV32 core: loads a program from a byte
// stream into instruction memory, and controls run / halt / single-step
// of the core, halting on a data-access fault.
module cpu_debug_controller #(
   parameter int unsigned COUNT_W = 15
) (
   input logic                   clk,
   input logic                   rst,
   cpu_debug_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      WRITE  = 3'd2,
      PRERUN = 3'd3,
      RUN    = 3'd4,
      STEP   = 3'd5,
      HALT   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] loaded_q;
   logic [COUNT_W-1:0] loaded_inc;
   logic [1:0]         byte_idx_q;
   logic [31:0]        word_q;
   logic               fault_q;

   logic load_acc, byte_xfer, fault_hit;
   logic run_w, step_w, load_w;

   // Only the highest-priority command of a cycle survives; fault and
   // halt are handled directly in the states where they matter.
   assign run_w  = bus.run_cmd  & ~bus.halt_cmd;
   assign step_w = bus.step_cmd & ~bus.halt_cmd & ~bus.run_cmd;
   assign load_w = bus.load_start & ~bus.halt_cmd & ~bus.run_cmd & ~bus.step_cmd
                   & (|bus.load_word_count);

   // Word counter saturates at the latched target count.
   assign loaded_inc = (loaded_q == count_q) ? loaded_q : loaded_q + COUNT_W'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and datapath enables.
   always_comb begin
      state_d   = state_q;
      load_acc  = 1'b0;
      byte_xfer = 1'b0;
      fault_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (run_w) begin
               state_d = PRERUN;
            end else if (load_w) begin
               state_d  = LOAD;
               load_acc = 1'b1;
            end
         end
         LOAD: begin
            if (bus.halt_cmd) begin
               state_d = IDLE;
            end else if (bus.byte_valid) begin
               byte_xfer = 1'b1;
               if (byte_idx_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            if (bus.halt_cmd || (loaded_inc == count_q)) state_d = IDLE;
            else                                          state_d = LOAD;
         end
         PRERUN: state_d = RUN;
         RUN: begin
            if (bus.fault || bus.halt_cmd) begin
               state_d   = HALT;
               fault_hit = bus.fault;
            end
         end
         STEP: begin
            state_d   = HALT;
            fault_hit = bus.fault;
         end
         HALT: begin
            if (run_w) begin
               state_d = RUN;
            end else if (step_w) begin
               state_d = STEP;
            end else if (load_w) begin
               state_d  = LOAD;
               load_acc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Load datapath: count latch, byte packing, word counter, fault flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         loaded_q   <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         fault_q    <= 1'b0;
      end else begin
         if (load_acc) begin
            count_q    <= bus.load_word_count;
            loaded_q   <= '0;
            byte_idx_q <= '0;
            fault_q    <= 1'b0;
         end
         if (byte_xfer) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= bus.byte_data;
            byte_idx_q                        <= byte_idx_q + 2'd1;
         end
         if (state_q == WRITE) loaded_q <= loaded_inc;
         if ((state_q == LOAD) && bus.halt_cmd) byte_idx_q <= '0;
         if (fault_hit) fault_q <= 1'b1;
      end
   end

   assign bus.byte_ready        = (state_q == LOAD);
   assign bus.instruction_write = (state_q == WRITE);
   assign bus.cpu_rst           = (state_q == LOAD) || (state_q == WRITE) || (state_q == PRERUN);
   assign bus.debug_enable      = (state_q == RUN) || (state_q == STEP);
   assign bus.instruction_in    = word_q;
   assign bus.fault_latched     = fault_q;
   assign bus.words_loaded      = loaded_q;
   assign bus.state             = state_q;

endmodule

// File: tb/tb_cpu_debug_controller.sv
// Bench for cpu_debug_controller: directed command/byte sequences, a
// mode-level reference model compared every cycle, and literal checks.
module tb_cpu_debug_controller;

   localparam int unsigned CW = 15;

   localparam int S_IDLE = 0, S_LOAD = 1, S_WRITE = 2, S_PRERUN = 3,
                  S_RUN = 4, S_STEP = 5, S_HALT = 6;
   localparam int C_NONE = 0, C_FAULT = 1, C_HALT = 2, C_RUN = 3,
                  C_STEP = 4, C_LOAD = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cpu_debug_controller_if #(.COUNT_W(CW)) bus ();

   cpu_debug_controller #(.COUNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int          m_mode   = 0;
   int          m_count  = 0;
   int          m_loaded = 0;
   int          m_nbytes = 0;
   logic [31:0] m_word   = '0;
   bit          m_fault  = 1'b0;
   bit          m_valid  = 1'b0;

   logic [31:0] exp_writes[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_begin_load();
      m_count  = int'(bus.load_word_count);
      m_loaded = 0;
      m_nbytes = 0;
      m_fault  = 1'b0;
      m_mode   = S_LOAD;
   endtask

   task automatic model_update();
      int w;
      if (rst) begin
         m_mode = S_IDLE; m_loaded = 0; m_nbytes = 0; m_word = '0; m_fault = 1'b0;
         m_valid = 1'b1;
         return;
      end
      w = bus.halt_cmd ? C_HALT : bus.run_cmd ? C_RUN : bus.step_cmd ? C_STEP :
          (bus.load_start && bus.load_word_count != '0) ? C_LOAD : C_NONE;
      if (bus.fault && (m_mode == S_RUN || m_mode == S_STEP)) w = C_FAULT;
      case (m_mode)
         S_IDLE: begin
            if (w == C_RUN) m_mode = S_PRERUN;
            else if (w == C_LOAD) model_begin_load();
         end
         S_LOAD: begin
            if (w == C_HALT) begin
               m_mode = S_IDLE; m_nbytes = 0;
            end else if (bus.byte_valid) begin
               m_word = {bus.byte_data, m_word[31:8]};
               m_nbytes++;
               if (m_nbytes == 4) begin m_nbytes = 0; m_mode = S_WRITE; end
            end
         end
         S_WRITE: begin
            if (m_loaded < m_count) m_loaded++;
            m_mode = (m_loaded == m_count || w == C_HALT) ? S_IDLE : S_LOAD;
         end
         S_PRERUN: m_mode = S_RUN;
         S_RUN: begin
            if (w == C_FAULT) begin m_fault = 1'b1; m_mode = S_HALT; end
            else if (w == C_HALT) m_mode = S_HALT;
         end
         S_STEP: begin
            if (w == C_FAULT) m_fault = 1'b1;
            m_mode = S_HALT;
         end
         S_HALT: begin
            if (w == C_RUN) m_mode = S_RUN;
            else if (w == C_STEP) m_mode = S_STEP;
            else if (w == C_LOAD) model_begin_load();
         end
         default: m_mode = S_IDLE;
      endcase
   endtask

   // Model advances on every active edge.
   initial forever begin
      @(posedge clk);
      model_update();
   end

   // Every-cycle comparison on the inactive edge.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("state", 32'(bus.state), 32'(m_mode));
         chk("byte_ready", 32'(bus.byte_ready), 32'(m_mode == S_LOAD));
         chk("instruction_write", 32'(bus.instruction_write), 32'(m_mode == S_WRITE));
         chk("cpu_rst", 32'(bus.cpu_rst), 32'(m_mode >= S_LOAD && m_mode <= S_PRERUN));
         chk("debug_enable", 32'(bus.debug_enable), 32'(m_mode == S_RUN || m_mode == S_STEP));
         chk("fault_latched", 32'(bus.fault_latched), 32'(m_fault));
         chk("words_loaded", 32'(bus.words_loaded), 32'(m_loaded));
         if (bus.instruction_write === 1'b1) begin
            chk("instruction_in_model", bus.instruction_in, m_word);
            if (exp_writes.size() == 0) chk("unexpected_write", bus.instruction_in, 32'hxxxx_xxxx);
            else chk("instruction_in_literal", bus.instruction_in, exp_writes.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.byte_data  = b;
      bus.byte_valid = 1'b1;
      while (bus.byte_ready !== 1'b1 && n < 20) begin tick(); n++; end
      chk("byte_wait_bound", 32'(n < 20), 32'd1);
      tick();
   endtask

   task automatic start_load(input int cnt);
      bus.load_start      = 1'b1;
      bus.load_word_count = CW'(cnt);
      tick();
      bus.load_start      = 1'b0;
   endtask

   task automatic pulse(input int which);
      case (which)
         C_RUN:   bus.run_cmd  = 1'b1;
         C_STEP:  bus.step_cmd = 1'b1;
         C_HALT:  bus.halt_cmd = 1'b1;
         C_FAULT: bus.fault    = 1'b1;
         default: ;
      endcase
      tick();
      bus.run_cmd = 1'b0; bus.step_cmd = 1'b0; bus.halt_cmd = 1'b0; bus.fault = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      logic [7:0] gap_bytes[4];
      int         gi;
      bus.byte_valid = 1'b0; bus.byte_data = '0; bus.load_start = 1'b0;
      bus.load_word_count = '0; bus.run_cmd = 1'b0; bus.step_cmd = 1'b0;
      bus.halt_cmd = 1'b0; bus.fault = 1'b0;

      // Reset state.
      tick(); tick();
      rst = 1'b0;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_instruction_in", bus.instruction_in, 32'h0);
      chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd0);

      // Two-word load with byte_valid held high.
      exp_writes.push_back(32'h0050_0013);
      exp_writes.push_back(32'h0010_0093);
      start_load(2);
      chk("load_state", 32'(bus.state), 32'd1);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      chk("load2_write_state", 32'(bus.state), 32'd2);
      bus.byte_valid = 1'b0;
      tick(); tick();
      chk("load2_done_state", 32'(bus.state), 32'd0);
      chk("load2_words", 32'(bus.words_loaded), 32'd2);

      // Reset held for two cycles in the middle of a load.
      start_load(3);
      send_byte(8'hAA); send_byte(8'hBB);
      bus.byte_valid = 1'b0;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("midload_rst_state", 32'(bus.state), 32'd0);
      chk("midload_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("midload_rst_words", 32'(bus.words_loaded), 32'd0);
      chk("midload_rst_cpu_rst", 32'(bus.cpu_rst), 32'd0);

      // Handshake gaps: byte_valid alternates, junk on invalid cycles.
      gap_bytes[0] = 8'hEF; gap_bytes[1] = 8'hBE; gap_bytes[2] = 8'hAD; gap_bytes[3] = 8'hDE;
      exp_writes.push_back(32'hDEAD_BEEF);
      start_load(1);
      gi = 0;
      for (int c = 0; c < 7; c++) begin
         if ((c % 2) == 0) begin
            bus.byte_valid = 1'b1; bus.byte_data = gap_bytes[gi]; gi++;
         end else begin
            bus.byte_valid = 1'b0; bus.byte_data = 8'hFF;
         end
         tick();
      end
      bus.byte_valid = 1'b0;
      chk("gap_write_state", 32'(bus.state), 32'd2);
      chk("gap_word", bus.instruction_in, 32'hDEAD_BEEF);
      tick();
      chk("gap_done_words", 32'(bus.words_loaded), 32'd1);

      // Run / halt / step.
      pulse(C_RUN);
      chk("prerun_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("prerun_debug_enable", 32'(bus.debug_enable), 32'd0);
      tick();
      chk("run_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      chk("run_debug_enable", 32'(bus.debug_enable), 32'd1);
      tick(); tick();
      pulse(C_HALT);
      chk("halt_state", 32'(bus.state), 32'd6);
      chk("halt_debug_enable", 32'(bus.debug_enable), 32'd0);
      for (int s = 0; s < 3; s++) begin
         pulse(C_STEP);
         chk("step_debug_enable_on", 32'(bus.debug_enable), 32'd1);
         tick();
         chk("step_debug_enable_off", 32'(bus.debug_enable), 32'd0);
         tick();
      end

      // Fault in RUN, sticky through run/halt, cleared by load.
      pulse(C_RUN);
      chk("resume_state", 32'(bus.state), 32'd4);
      tick();
      pulse(C_FAULT);
      chk("fault_state", 32'(bus.state), 32'd6);
      chk("fault_latched_set", 32'(bus.fault_latched), 32'd1);
      chk("fault_debug_enable", 32'(bus.debug_enable), 32'd0);
      pulse(C_RUN);
      tick();
      pulse(C_HALT);
      chk("fault_latched_hold", 32'(bus.fault_latched), 32'd1);
      exp_writes.push_back(32'h0000_10B7);
      start_load(1);
      chk("fault_cleared_by_load", 32'(bus.fault_latched), 32'd0);
      send_byte(8'hB7); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
      bus.byte_valid = 1'b0;
      tick(); tick();

      // Abort a load after two bytes of the second word.
      exp_writes.push_back(32'h0010_0113);
      start_load(2);
      send_byte(8'h13); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      bus.byte_valid = 1'b0;
      pulse(C_HALT);
      chk("abort_state", 32'(bus.state), 32'd0);
      chk("abort_words", 32'(bus.words_loaded), 32'd1);
      for (int k = 0; k < 4; k++) tick();
      chk("abort_no_write", 32'(bus.instruction_write), 32'd0);

      // run_cmd beats step_cmd in HALT.
      pulse(C_RUN); tick();
      pulse(C_HALT);
      bus.run_cmd = 1'b1; bus.step_cmd = 1'b1;
      tick();
      bus.run_cmd = 1'b0; bus.step_cmd = 1'b0;
      chk("run_over_step", 32'(bus.state), 32'd4);

      // Zero-count load ignored in IDLE.
      rst = 1'b1; tick(); rst = 1'b0;
      start_load(0);
      chk("zero_count_state", 32'(bus.state), 32'd0);
      tick(); tick();

      chk("pending_writes", 32'(exp_writes.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_debug_controller.md
Name: cpu_debug_controller

Overview:
- Front-end sequencer for the pipelined RV32 core.
- Loads a program into instruction memory from a byte stream with a valid/ready handshake, packing 4 bytes little-endian into one word and issuing one write strobe per word. Instruction memory addresses writes sequentially internally.
- Controls the core's run enable (debug_enable) and core reset for run, halt and single-step.
- Latches data-access faults and halts the core when one occurs.

Parameters:
COUNT_W, 15, width of the word counters; must represent 2^(ADDR_WIDTH-2) words (16384 for ADDR_WIDTH=16).

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
byte_valid  input  1  load byte available
byte_data  input  8  load byte
byte_ready  output  1  controller accepts byte this cycle
load_start  input  1  begin program load (pulse)
load_word_count  input  COUNT_W  number of words to load; sampled on accepted load_start
run_cmd  input  1  start/resume execution (pulse)
step_cmd  input  1  execute one cycle (pulse)
halt_cmd  input  1  stop execution / abort load (pulse)
fault  input  1  core data_access_fault_exception
instruction_write  output  1  instruction memory write strobe
instruction_in  output  32  instruction word to write
debug_enable  output  1  core run enable (0 = PC/IF frozen)
cpu_rst  output  1  synchronous reset to core
fault_latched  output  1  sticky fault flag
words_loaded  output  COUNT_W  words written in the current/last load
state  output  3  current state encoding

Behaviour:
- States (encoding):
  - IDLE=0, LOAD=1, WRITE=2, PRERUN=3, RUN=4, STEP=5, HALT=6.
  - Encoding 7 is illegal and returns to IDLE on the next cycle.
- Reset (rst=1 at a clock edge):
  - state=IDLE; words_loaded=0; fault_latched=0; byte index=0; assembled word=0.
  - Outputs after reset: byte_ready=0, instruction_write=0, instruction_in=0, debug_enable=0, cpu_rst=0.
  - rst overrides everything, including mid-load and mid-run.
- Outputs decoded from registered state (no combinational input-to-output paths):
  - byte_ready=1 only in LOAD.
  - instruction_write=1 only in WRITE.
  - cpu_rst=1 in LOAD, WRITE, PRERUN.
  - debug_enable=1 in RUN and STEP.
  - instruction_in = assembled word register.
- Command priority per cycle: fault > halt_cmd > run_cmd > step_cmd > load_start. Lower-priority commands arriving in the same cycle are dropped.
- IDLE:
  - load_start with load_word_count≠0: latch count, words_loaded←0, byte index←0, go to LOAD.
  - load_start with count=0: ignored.
  - run_cmd → PRERUN.
  - step_cmd and halt_cmd are ignored.
- LOAD:
  - A byte transfers when byte_valid & byte_ready.
  - Byte k (k=0..3) goes to word[8k+7:8k].
  - The transfer of byte 3 moves to WRITE next cycle and resets the byte index.
  - halt_cmd: go to IDLE, discard the partial word; words_loaded keeps its value.
- WRITE: exactly one cycle.
  - words_loaded increments.
  - If the new value equals the latched count → IDLE, else → LOAD.
  - halt_cmd in WRITE: the write still completes, then go to IDLE.
- PRERUN: exactly one cycle with cpu_rst=1 (PC→0, pipeline cleared), then RUN.
- RUN:
  - halt_cmd → HALT; debug_enable is 0 from the next cycle.
  - fault=1 → HALT and fault_latched←1.
- HALT:
  - run_cmd → RUN (resume; no core reset).
  - step_cmd → STEP.
  - load_start (count≠0) → LOAD and clears fault_latched.
- STEP:
  - debug_enable=1 for exactly one cycle, then HALT.
  - fault during STEP sets fault_latched; next state is still HALT.
- fault is ignored outside RUN and STEP.
- fault_latched is cleared only by rst or an accepted load_start.
- words_loaded saturates at the latched count; it never wraps.

Test Plan:
- Reset: assert rst for 2 cycles mid-LOAD → state=0, byte_ready=0, instruction_write=0, debug_enable=0, cpu_rst=0, words_loaded=0.
- Load 2 words:
  - Stimulus: load_start, count=2; bytes 0x13,0x00,0x50,0x00, then 0x93,0x00,0x10,0x00 with byte_valid held 1.
  - Response: exactly two single-cycle instruction_write pulses with instruction_in=0x00500013 then 0x00100093; cpu_rst=1 throughout; state returns to 0; words_loaded=2.
- Handshake gaps: byte_valid toggled 1/0 each cycle during a 1-word load → only the 4 valid-qualified bytes are packed; one write of the expected word.
- Run/halt/step:
  - run_cmd from IDLE → cpu_rst=1 for exactly 1 cycle, then debug_enable=1.
  - halt_cmd → debug_enable=0 next cycle, state=6.
  - Three step_cmd pulses → three single-cycle debug_enable pulses.
- Fault: fault=1 for one cycle in RUN → state=6, fault_latched=1, debug_enable=0. fault_latched holds through run_cmd/halt_cmd and clears on load_start with count=1.
- Abort and priority:
  - halt_cmd after 2 bytes of word 2 → state=0, words_loaded=1, no further write.
  - run_cmd and step_cmd in the same cycle in HALT → RUN.
  - load_start with count=0 in IDLE → no state change.
